// File: rtl/sample_loader.sv
// Sample loader: buffers an N-sample frame from a valid/ready stream and copies it to a cache.
// Optional fill_level output is enabled by defining SAMPLE_LOADER_FILL_LEVEL_EN.
module sample_loader #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              ce,
    input  logic [11:0]       sample_num,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              data_loaded,
    input  logic              load_to_cache,
    output logic              cache_we,
    output logic [11:0]       cache_addr,
    output logic [DATA_W-1:0] cache_data,
`ifdef SAMPLE_LOADER_FILL_LEVEL_EN
    output logic [11:0]       fill_level,
    output logic              data_to_cache_loaded
`else
    output logic              data_to_cache_loaded
`endif
);

    typedef enum logic [2:0] {IDLE, FILL, FULL, COPY, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [11:0]       n_reg;
    logic [11:0]       last_idx;
    logic [11:0]       wr_ptr;
    logic [11:0]       rd_ptr;
    logic              we_pend;
    logic              transfer;
    logic [DATA_W-1:0] sample_mem [DEPTH];

    assign last_idx = n_reg - 12'd1;
    assign cache_we = we_pend & ce;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state           = state;
        s_ready              = 1'b0;
        data_loaded          = 1'b0;
        data_to_cache_loaded = 1'b0;
        transfer             = 1'b0;
        case (state)
            IDLE: begin
                if (ce && (sample_num != 12'd0)) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                s_ready  = 1'b1;
                transfer = ce & s_valid;
                if (transfer && (wr_ptr == last_idx)) begin
                    next_state = FULL;
                end
            end
            FULL: begin
                data_loaded = 1'b1;
                if (ce && load_to_cache) begin
                    next_state = COPY;
                end
            end
            COPY: begin
                // Leave once the final write strobe is consumed by a ce edge.
                if (ce && we_pend && (cache_addr == last_idx)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                data_to_cache_loaded = 1'b1;
                if (ce && !load_to_cache) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst && transfer) begin
            sample_mem[wr_ptr] <= s_data;
        end
    end

    // The buffer read register doubles as the cache data output; the strobe trails it by zero cycles.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            n_reg      <= 12'd0;
            wr_ptr     <= 12'd0;
            rd_ptr     <= 12'd0;
            we_pend    <= 1'b0;
            cache_addr <= 12'd0;
            cache_data <= '0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (sample_num != 12'd0) begin
                        n_reg  <= sample_num;
                        wr_ptr <= 12'd0;
                    end
                    we_pend <= 1'b0;
                end
                FILL: begin
                    if (s_valid) begin
                        wr_ptr <= wr_ptr + 12'd1;
                    end
                end
                FULL: begin
                    if (load_to_cache) begin
                        rd_ptr <= 12'd0;
                    end
                    we_pend <= 1'b0;
                end
                COPY: begin
                    if (rd_ptr < n_reg) begin
                        cache_data <= sample_mem[rd_ptr];
                        cache_addr <= rd_ptr;
                        rd_ptr     <= rd_ptr + 12'd1;
                        we_pend    <= 1'b1;
                    end else begin
                        we_pend    <= 1'b0;
                    end
                end
                default: begin
                    we_pend <= 1'b0;
                end
            endcase
        end
    end

`ifdef SAMPLE_LOADER_FILL_LEVEL_EN
    always_comb begin
        fill_level = 12'd0;
        case (state)
            FILL:             fill_level = wr_ptr;
            FULL, COPY, DONE: fill_level = n_reg;
            default:          fill_level = 12'd0;
        endcase
    end
`endif

endmodule

// File: tb/tb_sample_loader.sv
// Self-checking bench for sample_loader: directed frames plus randomized frames against a queue model.
// Exercises fill_level checks when SAMPLE_LOADER_FILL_LEVEL_EN is defined.
module tb_sample_loader;

    logic        clk;
    logic        nrst;
    logic        ce;
    logic [11:0] sample_num;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        data_loaded;
    logic        load_to_cache;
    logic        cache_we;
    logic [11:0] cache_addr;
    logic [15:0] cache_data;
    logic        data_to_cache_loaded;
`ifdef SAMPLE_LOADER_FILL_LEVEL_EN
    logic [11:0] fill_level;
`endif

    int checks = 0;
    int errors = 0;
    logic [11:0] got_addr[$];
    logic [15:0] got_data[$];

    sample_loader #(.DATA_W(16), .DEPTH(4096)) dut (
        .clk(clk),
        .nrst(nrst),
        .ce(ce),
        .sample_num(sample_num),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .data_loaded(data_loaded),
        .load_to_cache(load_to_cache),
        .cache_we(cache_we),
        .cache_addr(cache_addr),
        .cache_data(cache_data),
`ifdef SAMPLE_LOADER_FILL_LEVEL_EN
        .fill_level(fill_level),
`endif
        .data_to_cache_loaded(data_to_cache_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each cycle with the strobe high at mid-cycle is exactly one cache write.
    always @(negedge clk) begin
        if (cache_we === 1'b1) begin
            got_addr.push_back(cache_addr);
            got_data.push_back(cache_data);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit ce_i, input bit valid_i, input logic [15:0] data_i,
                                 input bit load_i, input logic [11:0] num_i);
        ce            = ce_i;
        s_valid       = valid_i;
        s_data        = data_i;
        load_to_cache = load_i;
        sample_num    = num_i;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_s_ready"}, 32'(s_ready), 0);
        checkOutput({tag, "_data_loaded"}, 32'(data_loaded), 0);
        checkOutput({tag, "_cache_we"}, 32'(cache_we), 0);
        checkOutput({tag, "_cache_addr"}, 32'(cache_addr), 0);
        checkOutput({tag, "_cache_data"}, 32'(cache_data), 0);
        checkOutput({tag, "_dtcl"}, 32'(data_to_cache_loaded), 0);
`ifdef SAMPLE_LOADER_FILL_LEVEL_EN
        checkOutput({tag, "_fill_level"}, 32'(fill_level), 0);
`endif
    endtask

    // mode 0: ce/valid always high, data 10,20,...; 1: ce low every other cycle, valid toggling;
    // 2: random ce/valid/data, sample_num and load_to_cache disturbed mid-frame; 3: data 0x7FFF.
    task automatic runFrame(input int n, input int mode);
        logic [15:0] exp_q[$];
        int          accepted;
        int          ce_edges;
        int          cyc;
        bit          ce_v;
        bit          val_v;
        bit          load_v;
        logic [15:0] d;
        logic [11:0] num_v;
        got_addr.delete();
        got_data.delete();

        applyStimulus(1'b1, 1'b0, 16'd0, 1'b0, 12'(n));
        checkOutput("idle_s_ready", 32'(s_ready), 0);
        checkOutput("idle_data_loaded", 32'(data_loaded), 0);
        cycle();

        accepted = 0;
        cyc      = 0;
        while (accepted < n && cyc < 4000) begin
            case (mode)
                1: begin
                    ce_v  = (cyc % 2) == 1;
                    val_v = ((cyc / 2) % 2) == 1;
                end
                2: begin
                    ce_v  = $urandom_range(0, 3) != 0;
                    val_v = $urandom_range(0, 1) == 1;
                end
                default: begin
                    ce_v  = 1'b1;
                    val_v = 1'b1;
                end
            endcase
            if (mode == 0) d = 16'(10 * (accepted + 1));
            else if (mode == 3) d = 16'h7FFF;
            else d = 16'($urandom);
            num_v = (mode == 2) ? 12'($urandom) : 12'(n);
            applyStimulus(ce_v, val_v, d, 1'b0, num_v);
            checkOutput("fill_s_ready", 32'(s_ready), 1);
            checkOutput("fill_data_loaded", 32'(data_loaded), 0);
`ifdef SAMPLE_LOADER_FILL_LEVEL_EN
            checkOutput("fill_level_fill", 32'(fill_level), 32'(accepted));
`endif
            if (ce_v && val_v) begin
                exp_q.push_back(d);
                accepted++;
            end
            cycle();
            cyc++;
        end
        checkOutput("fill_accept_count", 32'(accepted), 32'(n));

        for (int k = 0; k < 3; k++) begin
            applyStimulus((mode == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          16'($urandom), 1'b0, 12'($urandom));
            checkOutput("full_s_ready", 32'(s_ready), 0);
            checkOutput("full_data_loaded", 32'(data_loaded), 1);
            checkOutput("full_dtcl", 32'(data_to_cache_loaded), 0);
            checkOutput("full_cache_we", 32'(cache_we), 0);
`ifdef SAMPLE_LOADER_FILL_LEVEL_EN
            checkOutput("fill_level_full", 32'(fill_level), 32'(n));
`endif
            cycle();
        end

        applyStimulus(1'b1, 1'b0, 16'd0, 1'b1, 12'(n));
        cycle();
        ce_edges = 0;
        cyc      = 0;
        while (cyc < 4000) begin
            if (data_to_cache_loaded === 1'b1) break;
            case (mode)
                1:       ce_v = (cyc % 2) == 1;
                2:       ce_v = $urandom_range(0, 2) != 0;
                default: ce_v = 1'b1;
            endcase
            load_v = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            applyStimulus(ce_v, 1'($urandom_range(0, 1)), 16'($urandom), load_v, 12'($urandom));
            checkOutput("copy_data_loaded", 32'(data_loaded), 0);
            checkOutput("copy_s_ready", 32'(s_ready), 0);
            if (ce_v) ce_edges++;
            cycle();
            cyc++;
        end
        checkOutput("copy_reached_done", 32'(data_to_cache_loaded), 1);
        checkOutput("copy_ce_cycles", 32'(ce_edges), 32'(n + 1));

        checkOutput("cache_write_count", 32'(got_addr.size()), 32'(n));
        for (int i = 0; i < got_addr.size() && i < n; i++) begin
            checkOutput("cache_write_addr", 32'(got_addr[i]), 32'(i));
            checkOutput("cache_write_data", 32'(got_data[i]), 32'(exp_q[i]));
        end

        applyStimulus(1'b1, 1'b0, 16'd0, 1'b1, 12'd0);
        checkOutput("done_dtcl_hold", 32'(data_to_cache_loaded), 1);
        checkOutput("done_s_ready", 32'(s_ready), 0);
`ifdef SAMPLE_LOADER_FILL_LEVEL_EN
        checkOutput("fill_level_done", 32'(fill_level), 32'(n));
`endif
        cycle();
        applyStimulus(1'b1, 1'b0, 16'd0, 1'b0, 12'd0);
        checkOutput("done_dtcl_before_release", 32'(data_to_cache_loaded), 1);
        cycle();
        applyStimulus(1'b1, 1'b1, 16'($urandom), 1'b0, 12'd0);
        checkOutput("idle_dtcl_cleared", 32'(data_to_cache_loaded), 0);
        checkOutput("idle_after_done_s_ready", 32'(s_ready), 0);
        checkOutput("idle_after_done_loaded", 32'(data_loaded), 0);
        cycle();
    endtask

    initial begin
        int base;
        nrst = 1'b0;
        applyStimulus(1'b0, 1'b1, 16'h1234, 1'b1, 12'd5);
        cycle();
        cycle();
        checkResetOutputs("reset");
        nrst = 1'b1;

        $display("[TB] frame N=4 with samples 10,20,30,40");
        runFrame(4, 0);
        $display("[TB] frame N=3 with ce gaps and toggling valid");
        runFrame(3, 1);

        $display("[TB] sample_num=0 holds IDLE");
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b1, 16'($urandom), 1'($urandom_range(0, 1)), 12'd0);
            checkOutput("num0_s_ready", 32'(s_ready), 0);
            checkOutput("num0_data_loaded", 32'(data_loaded), 0);
            cycle();
        end
        runFrame(1, 3);

        $display("[TB] randomized frames");
        for (int f = 0; f < 5; f++) begin
            runFrame($urandom_range(1, 40), 2);
        end

        $display("[TB] reset mid-COPY with N=8");
        got_addr.delete();
        got_data.delete();
        applyStimulus(1'b1, 1'b0, 16'd0, 1'b0, 12'd8);
        cycle();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b1, 16'(100 + k), 1'b0, 12'd8);
            cycle();
        end
        applyStimulus(1'b1, 1'b0, 16'd0, 1'b1, 12'd0);
        cycle();
        for (int k = 0; k < 50 && got_addr.size() < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 16'd0, 1'b1, 12'd0);
            cycle();
        end
        checkOutput("rst_copy_writes_before", 32'(got_addr.size()), 3);
        nrst = 1'b0;
        applyStimulus(1'b1, 1'b0, 16'd0, 1'b1, 12'd0);
        cycle();
        nrst = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'd0, 1'b1, 12'd0);
        checkResetOutputs("rst_copy");
        base = got_addr.size();
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, 1'b1, 16'($urandom), 1'b1, 12'd0);
            checkOutput("rst_copy_no_we", 32'(cache_we), 0);
            cycle();
        end
        checkOutput("rst_copy_no_more_writes", 32'(got_addr.size()), 32'(base));

        $display("[TB] frame after reset recovery");
        runFrame(5, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_loader.md
SAMPLE_LOADER -- requirements
Module: sample_loader

Interface
REQ-001 Parameter DATA_W, default 16, sample width in bits.
REQ-002 Parameter DEPTH, default 4096, buffer depth in samples; address width 12.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 nrst  in  1  reset, synchronous, active-low.
REQ-005 ce  in  1  clock enable; state, pointers and registered outputs advance only when ce=1.
REQ-006 sample_num  in  12  frame length N in samples; sampled on IDLE->FILL.
REQ-007 s_valid  in  1  upstream sample valid.
REQ-008 s_data  in  DATA_W  upstream sample, two's complement.
REQ-009 s_ready  out  1  loader accepts a sample this cycle.
REQ-010 data_loaded  out  1  level: frame of N samples buffered.
REQ-011 load_to_cache  in  1  level from the control FSM: copy buffer to cache.
REQ-012 cache_we  out  1  cache write strobe.
REQ-013 cache_addr  out  12  cache write address.
REQ-014 cache_data  out  DATA_W  cache write data.
REQ-015 data_to_cache_loaded  out  1  level: copy of all N samples complete.

Function
REQ-016 States SHALL be IDLE, FILL, FULL, COPY, DONE.
REQ-017 IDLE: if sample_num!=0, latch N=sample_num, wr_ptr=0, go FILL; if sample_num==0, stay IDLE.
REQ-018 FILL: s_ready=1 (combinational from state); transfer = s_valid & s_ready & ce writes s_data to buf[wr_ptr], wr_ptr+1.
REQ-019 The transfer with wr_ptr==N-1 SHALL move to FULL; s_ready=0 in every state but FILL.
REQ-020 FULL: data_loaded=1; on load_to_cache=1 go COPY, rd_ptr=0; data_loaded drops on the COPY entry cycle.
REQ-021 COPY: buffer read is synchronous, 1 cycle; read addr rd_ptr, rd_ptr+1 per ce cycle for N reads.
REQ-022 Cache write i (cache_we=1, cache_addr=i, cache_data=buf[i]) SHALL occur one ce cycle after read i; N writes, consecutive addresses 0..N-1.
REQ-023 cache_we SHALL be the registered strobe ANDed with ce; no write is repeated or lost across ce=0 gaps.
REQ-024 After write N-1 the block SHALL enter DONE; COPY entry to DONE takes N+1 ce cycles.
REQ-025 DONE: data_to_cache_loaded=1; when load_to_cache=0 go IDLE, data_to_cache_loaded=0.
REQ-026 load_to_cache dropping in COPY SHALL be ignored; copy completes.
REQ-027 sample_num changes outside IDLE SHALL have no effect on the current frame.
REQ-028 Transfers SHALL be counted only in FILL; s_valid elsewhere is ignored, nothing stored.

Reset
REQ-029 nrst=0 SHALL force IDLE, wr_ptr=rd_ptr=N=0, s_ready=0, data_loaded=0, cache_we=0, cache_addr=0, cache_data=0, data_to_cache_loaded=0, regardless of ce.
REQ-030 Reset mid-FILL or mid-COPY SHALL abandon the frame; buffer contents undefined, no further cache writes.

Configuration
REQ-031 Macro SAMPLE_LOADER_FILL_LEVEL_EN defined: output fill_level (12 bits) = wr_ptr in FILL, N in FULL/COPY/DONE, 0 in IDLE, reset 0.
REQ-032 Macro undefined: port fill_level and its logic absent; all other behaviour identical.

Verification
REQ-033 sample_num=4, 4 back-to-back valid samples 10,20,30,40 -> FULL, data_loaded=1, s_ready=0 after 4th transfer.
REQ-034 Then load_to_cache=1 -> cache writes addr 0..3 data 10,20,30,40, DONE 5 cycles after COPY entry, data_to_cache_loaded=1 until load_to_cache=0, then IDLE.
REQ-035 sample_num=3, s_valid toggled and ce low every other cycle -> exactly 3 samples stored, no duplicate or skipped cache write.
REQ-036 sample_num=0 -> stays IDLE, s_ready=0 indefinitely; then sample_num=1, one sample 0x7FFF -> single cache write addr 0 data 0x7FFF.
REQ-037 nrst=0 for one cycle mid-COPY with N=8 after 3 writes -> next cycle all outputs at reset values, no further cache_we.
REQ-038 With SAMPLE_LOADER_FILL_LEVEL_EN, N=4 after 2 transfers -> fill_level=2; in FULL -> 4.
